// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-RAM arbiter between the CPU MEM stage
// and the debug/boot-loader master.
package dmem_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } arb_state_e;

    // Debug accesses at or above this byte address target peripherals, not RAM.
    localparam logic [31:0] PERIPH_BASE = 32'h4000_0000;

endpackage

// File: rtl/dmem_arbiter.sv
// Single-port data RAM arbiter: the CPU MEM stage has priority; a blocked debug
// request is force-granted (stalling the pipeline) once it has waited STARVE_LIMIT cycles.
import dmem_arb_pkg::*;

module dmem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 8,
    parameter int unsigned CNT_W        = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cpu_rd,
    input  logic             cpu_wr,
    input  logic [31:0]      cpu_addr,
    input  logic [31:0]      cpu_wdata,
    output logic [31:0]      cpu_rdata,
    output logic             cpu_stall,
    input  logic             dbg_req,
    input  logic             dbg_we,
    input  logic [31:0]      dbg_addr,
    input  logic [31:0]      dbg_wdata,
    output logic             dbg_ack,
    output logic             dbg_err,
    output logic [31:0]      dbg_rdata,
    output logic             ram_rd,
    output logic             ram_wr,
    output logic [31:0]      ram_addr,
    output logic [31:0]      ram_wdata,
    input  logic [31:0]      ram_rdata,
    output logic             arb_state,
    output logic [CNT_W-1:0] starve_cnt
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    arb_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             ack_q;
    logic             err_q;
    logic [31:0]      rdata_q;

    logic cpu_act;
    logic dbg_ok;
    logic grant;

    // Handshake: dbg_req (with we/addr/wdata stable) is held until the one-cycle
    // dbg_ack pulse; dbg_err and dbg_rdata are valid in that same cycle.
    always_comb begin
        cpu_act   = cpu_rd | cpu_wr;
        dbg_ok    = (dbg_addr < PERIPH_BASE);
        grant     = (state_q == IDLE) && dbg_req && (!cpu_act || (cnt_q == LIMIT));

        ram_rd    = cpu_rd;
        ram_wr    = cpu_wr;
        ram_addr  = cpu_addr;
        ram_wdata = cpu_wdata;
        cpu_stall = 1'b0;
        if (grant) begin
            ram_rd    = !dbg_we && dbg_ok;
            ram_wr    = dbg_we && dbg_ok;
            ram_addr  = dbg_addr;
            ram_wdata = dbg_wdata;
            cpu_stall = cpu_act;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant) begin
                        state_q <= ACK;
                        ack_q   <= 1'b1;
                        err_q   <= !dbg_ok;
                        rdata_q <= (!dbg_we && dbg_ok) ? ram_rdata : 32'h0;
                    end else begin
                        ack_q <= 1'b0;
                        // Saturate so the forced grant stays armed while the CPU keeps the RAM busy.
                        if (dbg_req && cpu_act && (cnt_q != LIMIT)) begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                ACK: begin
                    state_q <= IDLE;
                    ack_q   <= 1'b0;
                    cnt_q   <= '0;
                end
                default: begin
                    state_q <= IDLE;
                    ack_q   <= 1'b0;
                end
            endcase
        end
    end

    assign cpu_rdata  = ram_rdata;
    assign dbg_ack    = ack_q;
    assign dbg_err    = err_q;
    assign dbg_rdata  = rdata_q;
    assign arb_state  = state_q;
    assign starve_cnt = cnt_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: behavioural RAM, debug responses checked
// against an expected queue, grant/stall timing checked cycle by cycle.
module tb_dmem_arbiter;

    logic        clk;
    logic        reset;
    logic        cpu_rd, cpu_wr;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_stall;
    logic        dbg_req, dbg_we;
    logic [31:0] dbg_addr, dbg_wdata;
    logic        dbg_ack, dbg_err;
    logic [31:0] dbg_rdata;
    logic        ram_rd, ram_wr;
    logic [31:0] ram_addr, ram_wdata, ram_rdata;
    logic        arb_state;
    logic [3:0]  starve_cnt;

    logic [31:0] mem [0:255];
    logic [32:0] exp_q [$];
    int          n_chk;
    int          n_pass;
    int          stalls;

    dmem_arbiter #(.STARVE_LIMIT(8), .CNT_W(4)) dut (
        .clk(clk), .reset(reset),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_ack(dbg_ack), .dbg_err(dbg_err), .dbg_rdata(dbg_rdata),
        .ram_rd(ram_rd), .ram_wr(ram_wr), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .arb_state(arb_state), .starve_cnt(starve_cnt)
    );

    // clock / RAM model
    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign ram_rdata = mem[ram_addr[9:2]];
    always @(posedge clk) begin
        if (ram_wr) mem[ram_addr[9:2]] <= ram_wdata;
    end

    task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cpu(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
        cpu_rd = rd; cpu_wr = wr; cpu_addr = a; cpu_wdata = d;
    endtask

    task automatic set_dbg(input logic req, input logic we, input logic [31:0] a, input logic [31:0] d);
        dbg_req = req; dbg_we = we; dbg_addr = a; dbg_wdata = d;
    endtask

    // scoreboard: every ack consumes one expected {err, rdata}
    always @(negedge clk) begin
        logic [32:0] e;
        if (reset && dbg_ack) begin
            if (exp_q.size() == 0) begin
                check("unexpected_ack", 33'(1), 33'(0));
            end else begin
                e = exp_q.pop_front();
                check("dbg_resp", {dbg_err, dbg_rdata}, e);
            end
        end
    end

    initial begin
        n_chk = 0; n_pass = 0; stalls = 0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        reset = 1'b0;
        set_cpu(0, 0, 0, 0);
        set_dbg(0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", 33'(dbg_ack), 33'(0));
        check("rst_err", 33'(dbg_err), 33'(0));
        check("rst_rdata", 33'(dbg_rdata), 33'(0));
        check("rst_state", 33'(arb_state), 33'(0));
        check("rst_cnt", 33'(starve_cnt), 33'(0));
        reset = 1'b1;
        cycle();

        // CPU idle: debug write then read back
        set_dbg(1, 1, 32'h10, 32'hDEAD_BEEF);
        exp_q.push_back({1'b0, 32'h0});
        #1;
        check("w_ram_wr", 33'(ram_wr), 33'(1));
        check("w_ram_addr", 33'(ram_addr), 33'h10);
        check("w_ram_wdata", 33'(ram_wdata), 33'hDEAD_BEEF);
        check("w_stall", 33'(cpu_stall), 33'(0));
        cycle();
        check("w_ack", 33'(dbg_ack), 33'(1));
        set_dbg(0, 0, 0, 0);
        cycle();
        set_dbg(1, 0, 32'h10, 32'h0);
        exp_q.push_back({1'b0, 32'hDEAD_BEEF});
        #1;
        check("r_ram_rd", 33'(ram_rd), 33'(1));
        cycle();
        check("r_ack", 33'(dbg_ack), 33'(1));
        set_dbg(0, 0, 0, 0);
        cycle();

        // CPU busy every cycle: forced grant in cycle 9, ack in cycle 10
        set_cpu(1, 0, 32'h40, 32'h0);
        set_dbg(1, 0, 32'h10, 32'h0);
        exp_q.push_back({1'b0, 32'hDEAD_BEEF});
        for (int n = 1; n <= 9; n++) begin
            #1;
            check($sformatf("starve_stall_c%0d", n), 33'(cpu_stall), 33'(n == 9));
            check($sformatf("starve_cnt_c%0d", n), 33'(starve_cnt), 33'((n - 1 > 8) ? 8 : n - 1));
            if (n == 1) check("cpu_owns_ram", 33'(ram_addr), 33'h40);
            cycle();
        end
        check("starve_ack", 33'(dbg_ack), 33'(1));
        check("starve_ack_stall", 33'(cpu_stall), 33'(0));
        set_dbg(0, 0, 0, 0);
        set_cpu(0, 0, 0, 0);
        cycle();

        // 100 cycles, CPU busy, requests held: one stall every 10 cycles
        set_cpu(1, 0, 32'h44, 32'h0);
        set_dbg(1, 0, 32'h10, 32'h0);
        for (int n = 1; n <= 100; n++) begin
            #1;
            check($sformatf("window_stall_c%0d", n), 33'(cpu_stall), 33'((n % 10) == 9));
            if ((n % 10) == 9) exp_q.push_back({1'b0, 32'hDEAD_BEEF});
            stalls += int'(cpu_stall);
            cycle();
        end
        set_dbg(0, 0, 0, 0);
        set_cpu(0, 0, 0, 0);
        check("window_stall_total", 33'(stalls), 33'(10));
        cycle();

        // same-address conflict: debug writes on the forced grant, CPU write replays after
        set_cpu(1, 0, 32'h40, 32'h0);
        set_dbg(1, 1, 32'h20, 32'h2222);
        exp_q.push_back({1'b0, 32'h0});
        repeat (8) cycle();
        set_cpu(0, 1, 32'h20, 32'h1111);
        #1;
        check("conf_stall", 33'(cpu_stall), 33'(1));
        check("conf_dbg_wdata", 33'(ram_wdata), 33'h2222);
        check("conf_dbg_wr", 33'(ram_wr), 33'(1));
        cycle();
        check("conf_ack", 33'(dbg_ack), 33'(1));
        check("conf_replay_wdata", 33'(ram_wdata), 33'h1111);
        set_dbg(0, 0, 0, 0);
        cycle();
        set_cpu(0, 0, 0, 0);
        set_dbg(1, 0, 32'h20, 32'h0);
        exp_q.push_back({1'b0, 32'h1111});
        cycle();
        check("conf_read_ack", 33'(dbg_ack), 33'(1));
        set_dbg(0, 0, 0, 0);
        cycle();

        // peripheral-space rejection, then the last RAM word just below the boundary
        set_dbg(1, 0, 32'h4000_000C, 32'h0);
        exp_q.push_back({1'b1, 32'h0});
        #1;
        check("periph_no_rd", 33'(ram_rd), 33'(0));
        check("periph_no_wr", 33'(ram_wr), 33'(0));
        cycle();
        check("periph_ack", 33'(dbg_ack), 33'(1));
        set_dbg(0, 0, 0, 0);
        cycle();
        set_dbg(1, 0, 32'h3FFF_FFFC, 32'h0);
        exp_q.push_back({1'b0, 32'h0});
        #1;
        check("edge_ram_rd", 33'(ram_rd), 33'(1));
        cycle();
        set_dbg(0, 0, 0, 0);
        cycle();

        // reset during ACK drops the ack; grant resumes in first cycle after release
        set_cpu(1, 0, 32'h40, 32'h0);
        set_dbg(1, 1, 32'h30, 32'h5555);
        repeat (9) cycle();
        check("rack_ack", 33'(dbg_ack), 33'(1));
        check("rack_cnt_sat", 33'(starve_cnt), 33'(8));
        reset = 1'b0;
        #1;
        check("rack_ack_drop", 33'(dbg_ack), 33'(0));
        check("rack_state", 33'(arb_state), 33'(0));
        check("rack_cnt", 33'(starve_cnt), 33'(0));
        set_cpu(0, 0, 0, 0);
        cycle();
        reset = 1'b1;
        exp_q.push_back({1'b0, 32'h0});
        #1;
        check("rel_grant_wr", 33'(ram_wr), 33'(1));
        check("rel_grant_addr", 33'(ram_addr), 33'h30);
        cycle();
        check("rel_ack", 33'(dbg_ack), 33'(1));
        set_dbg(0, 0, 0, 0);
        cycle();

        // dbg_req held through ACK: grants at t and t+2, acks at t+1 and t+3
        set_dbg(1, 0, 32'h10, 32'h0);
        exp_q.push_back({1'b0, 32'hDEAD_BEEF});
        exp_q.push_back({1'b0, 32'hDEAD_BEEF});
        #1;
        check("held_t_grant", 33'(ram_rd), 33'(1));
        cycle();
        check("held_t1_ack", 33'(dbg_ack), 33'(1));
        check("held_t1_nogrant", 33'(ram_rd), 33'(0));
        cycle();
        check("held_t2_grant", 33'(ram_rd), 33'(1));
        check("held_t2_noack", 33'(dbg_ack), 33'(0));
        cycle();
        check("held_t3_ack", 33'(dbg_ack), 33'(1));
        set_dbg(0, 0, 0, 0);
        #1;
        check("held_t3_nogrant", 33'(ram_rd), 33'(0));
        cycle();

        repeat (2) cycle();
        check("sb_empty", 33'(exp_q.size()), 33'(0));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter for the single-port data RAM behind the pipeline's MEM stage. Port C is the CPU MEM stage (MemRd/MemWr, ALU-result address, BusB data); port D is a debug/boot-loader master with a req/ack handshake. The CPU has priority. A starvation counter forces a one-cycle debug grant by stalling the pipeline. Peripheral-space addresses from port D are rejected.

## Interface
- STARVE_LIMIT, 8: consecutive cycles a pending debug request may be blocked before a forced grant (1..15)
- CNT_W, 4: starvation counter width; must hold STARVE_LIMIT
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- cpu_rd  in  1  CPU MEM-stage read request
- cpu_wr  in  1  CPU MEM-stage write request
- cpu_addr  in  32  CPU byte address
- cpu_wdata  in  32  CPU write data
- cpu_rdata  out  32  RAM read data to CPU (combinational pass-through)
- cpu_stall  out  1  holds PC, IF/ID, ID/EX and EX/MEM for this cycle
- dbg_req  in  1  debug request, held until dbg_ack
- dbg_we  in  1  1 = write, 0 = read; stable while dbg_req
- dbg_addr  in  32  debug byte address; stable while dbg_req
- dbg_wdata  in  32  debug write data
- dbg_ack  out  1  one-cycle completion pulse (registered)
- dbg_err  out  1  valid with dbg_ack; address at or above PERIPH_BASE
- dbg_rdata  out  32  registered read data, valid with dbg_ack
- ram_rd, ram_wr  out  1 each  RAM strobes
- ram_addr  out  32  RAM address
- ram_wdata  out  32  RAM write data
- ram_rdata  in  32  RAM read data (combinational read, synchronous write)

## Operation
- States: IDLE, ACK. The state is held in a register; the grant is combinational from state and inputs.
- `cpu_act` = cpu_rd | cpu_wr. `dbg_ok` = dbg_addr < PERIPH_BASE.
- Debug grant in IDLE: dbg_req & (!cpu_act | cnt == STARVE_LIMIT).
- **When grant is asserted:**
  - RAM mux selects port D.
  - ram_wr = dbg_we & dbg_ok; ram_rd = !dbg_we & dbg_ok.
  - cpu_stall = cpu_act.
  - Next state is ACK.
  - On the clock edge: dbg_rdata <= ram_rdata (read with dbg_ok) or 0; dbg_err <= !dbg_ok.
- **Otherwise:**
  - RAM mux selects port C; cpu_stall = 0.
  - cnt increments, saturating at STARVE_LIMIT, when dbg_req & cpu_act. Otherwise cnt holds.
- **ACK:**
  - dbg_ack = 1. Port C owns the RAM and cpu_stall = 0.
  - cnt <= 0. Next state is IDLE.
  - dbg_req high in ACK is ignored.
  - dbg_req still high in the following IDLE cycle starts a new transaction.
- cpu_rdata always equals ram_rdata. The CPU ignores it while stalled.
- **Forced grant with a conflicting address:** the stalled CPU access replays the next cycle. A CPU write therefore lands after the debug write, and the CPU value wins.
- **Rejected debug access:** no RAM strobe; dbg_rdata = 0; dbg_err = 1.

## Timing
- Reset values: state IDLE, cnt 0, dbg_ack 0, dbg_err 0, dbg_rdata 0.
- Combinational outputs during reset follow IDLE with cnt 0.
- Reset during ACK discards the pending ack. The requester must reissue.
- Debug latency, CPU idle: grant in the first cycle dbg_req is high; ack on the next cycle.
- Debug latency, CPU continuously busy: ack at most STARVE_LIMIT+2 cycles after dbg_req rises.
- cpu_stall is high for at most 1 cycle in any STARVE_LIMIT+2 window.
- cpu_stall is never asserted when dbg_req is low.
- dbg_req & cpu_act with cnt < STARVE_LIMIT: CPU served, no stall.

## Structure
- Package `dmem_arb_pkg`: state enum (IDLE, ACK) and constant PERIPH_BASE = 32'h4000_0000.
- Single module. The starvation counter is inline (small saturating counter), so no sub-module is needed.

## Test plan
- **CPU idle, debug write:** dbg_req/we, addr 0x10, data 0xDEADBEEF. Required: ram_wr same cycle, dbg_ack next cycle with dbg_err=0, no stall. A following debug read of 0x10 returns 0xDEADBEEF with dbg_ack.
- **CPU busy every cycle, STARVE_LIMIT=8:**
  - With dbg_req held: cnt reaches 8 after 8 cycles, cpu_stall high exactly in cycle 9 with the debug grant, and dbg_ack in cycle 10.
  - Over 100 cycles, cpu_stall pulses once per 10 cycles while requests repeat.
- **Same-address conflict:** CPU writes 0x1111 to 0x20 and debug writes 0x2222 to 0x20 on the forced grant. The CPU replays; a later read of 0x20 returns 0x1111.
- **Debug read at 0x4000_000C:** no ram_rd or ram_wr, dbg_ack with dbg_err=1 and dbg_rdata=0.
- **Reset in ACK cycle:** assert reset low. dbg_ack drops immediately, state is IDLE, cnt=0. After release with dbg_req high and the CPU idle, the grant occurs in the first cycle.
- **dbg_req held through ACK:** exactly two grants, on cycles t and t+2, with acks on t+1 and t+3.
